seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width, SHALL be >= 4 and a power of two.
REQ-002 Parameter OPW, default 4: opcode width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 opcode  input  OPW  operation select.
REQ-008 in0  input  WIDTH  first operand.
REQ-009 in1  input  WIDTH  second operand / shift amount.
REQ-010 out_valid  output  1  result and status valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WIDTH  registered result.
REQ-013 status  output  4  registered flags {N,Z,C,V}, bit3..bit0.
REQ-014 err  output  1  registered illegal-opcode flag, valid with out_valid.

Function
REQ-015 Opcodes SHALL be AND=0, OR=1, XOR=2, ADD=3, SUB=4, SLL=5, SRL=6, MUL=7; all others illegal.
REQ-016 FSM states IDLE, EXEC, MULT, DONE; IDLE->EXEC on in_valid&&in_ready for opcodes 0-6 or illegal; IDLE->MULT for MUL; EXEC->DONE after one cycle; MULT->DONE after WIDTH iterations; DONE->IDLE when out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; opcode and operands are captured on the accepting edge, and input changes afterwards SHALL NOT affect the result.
REQ-018 out_valid SHALL be 1 only in DONE; out, status, err SHALL hold stable until the edge where out_valid&&out_ready.
REQ-019 Single-cycle ops: accept at edge N, out_valid rises at edge N+2; MUL: out_valid rises at edge N+WIDTH+2.
REQ-020 ADD/SUB SHALL compute modulo 2^WIDTH; C = carry-out (ADD) or borrow (SUB, set when in0<in1 unsigned); V = two's-complement signed overflow.
REQ-021 SLL/SRL shift logically by in1 unsigned; in1 >= WIDTH SHALL give out=0; C=V=0.
REQ-022 MUL SHALL use unsigned shift-add, one partial product per cycle; out = low WIDTH bits; C=1 iff high WIDTH bits nonzero; V=0.
REQ-023 AND/OR/XOR: C=V=0.
REQ-024 N=out[WIDTH-1], Z=(out==0), computed for every legal opcode.
REQ-025 Illegal opcode: out=0, status=4'b0100, err=1; otherwise err=0.
REQ-026 out_ready asserted outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored (not queued).
REQ-027 Back-to-back: DONE->IDLE transition costs one cycle before next acceptance.

Reset
REQ-028 rst high SHALL immediately force state IDLE, in_ready=0, out_valid=0, out=0, status=0, err=0, and abort any in-flight MUL.
REQ-029 in_ready SHALL rise on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro SEQ_ALU_MUL_EN defined: MUL implemented per REQ-022.
REQ-031 Macro SEQ_ALU_MUL_EN undefined: multiplier logic and MULT state absent; opcode 7 treated as illegal per REQ-025.

Structure
REQ-032 Package seq_alu_pkg SHALL hold the opcode constants, FSM state encoding and status bit indices (N=3, Z=2, C=1, V=0).
REQ-033 Iterative multiplier SHALL be sub-module seq_alu_mul (start, operands, done, WIDTH-bit low/high product), instantiated only under SEQ_ALU_MUL_EN.

Verification
REQ-034 ADD 16'h7FFF+16'h0001, out_ready=1 -> out=16'h8000, status=4'b1001, err=0, out_valid 2 cycles after acceptance.
REQ-035 SUB 16'h0003-16'h0005 -> out=16'hFFFE, status=4'b1010; SUB 5-5 -> out=0, status=4'b0100.
REQ-036 MUL 16'h0100*16'h0100 with macro -> out=0, status=4'b0110 after 18 cycles; without macro -> err=1, out=0.
REQ-037 SLL 16'h0001 by 15 -> 16'h8000, N=1; SRL by 16 -> out=0, Z=1; opcode 4'hF -> err=1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE while toggling inputs -> out/status unchanged, in_ready=0; release -> in_ready=1 one cycle later.
REQ-039 Assert rst mid-MUL -> out_valid, out, status drop to 0 without a clock edge; next request after reset completes correctly.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcodes, FSM state encoding and status bit positions.
// Build option SEQ_ALU_MUL_EN adds the MULT state and the iterative multiplier.
package seq_alu_pkg;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_OR  = 1;
  localparam int unsigned OP_XOR = 2;
  localparam int unsigned OP_ADD = 3;
  localparam int unsigned OP_SUB = 4;
  localparam int unsigned OP_SLL = 5;
  localparam int unsigned OP_SRL = 6;
  localparam int unsigned OP_MUL = 7;

  localparam int unsigned STATUS_W = 4;
  localparam int unsigned ST_N = 3;
  localparam int unsigned ST_Z = 2;
  localparam int unsigned ST_C = 1;
  localparam int unsigned ST_V = 0;

  localparam logic [STATUS_W-1:0] STATUS_ILLEGAL = 4'b0100;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2,
    S_MULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done pulses for one cycle together with the final accumulation; lo/hi hold until next start.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(WIDTH);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign lo = acc[WIDTH-1:0];
  assign hi = acc[PW-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and registered result/status/err.
// Define SEQ_ALU_MUL_EN to include the iterative multiplier (opcode 7); otherwise opcode 7 is illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPW-1:0]      opcode,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic [STATUS_W-1:0] status,
  output logic                err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t state, state_next;

  logic [OPW-1:0]      op_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                accept;
  logic                fire;
  logic                load_out;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic                shift_oob;
  logic [WIDTH-1:0]    res;
  logic [STATUS_W-1:0] res_st;
  logic                res_c;
  logic                res_v;
  logic                res_err;

`ifdef SEQ_ALU_MUL_EN
  logic                mul_start;
  logic                mul_done;
  logic [WIDTH-1:0]    mul_lo;
  logic [WIDTH-1:0]    mul_hi;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (in0),
    .b     (in1),
    .done  (mul_done),
    .lo    (mul_lo),
    .hi    (mul_hi)
  );
`endif

  // in_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign load_out = (state == S_DONE) && !out_valid;

  // Next-state logic
  always_comb begin
    state_next = state;
`ifdef SEQ_ALU_MUL_EN
    mul_start  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (opcode == OPW'(OP_MUL)) begin
            state_next = S_MULT;
            mul_start  = 1'b1;
          end else begin
            state_next = S_EXEC;
          end
`else
          state_next = S_EXEC;
`endif
        end
      end
      S_EXEC: state_next = S_DONE;
`ifdef SEQ_ALU_MUL_EN
      S_MULT: if (mul_done) state_next = S_DONE;
`endif
      S_DONE: if (fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result and flags from the captured request
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    shift_oob = (b_q >= WIDTH'(WIDTH));
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_err   = 1'b0;
    res_st    = '0;
    case (op_q)
      OPW'(OP_AND): res = a_q & b_q;
      OPW'(OP_OR):  res = a_q | b_q;
      OPW'(OP_XOR): res = a_q ^ b_q;
      OPW'(OP_ADD): begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OPW'(OP_SLL): res = shift_oob ? '0 : (a_q << b_q[SHW-1:0]);
      OPW'(OP_SRL): res = shift_oob ? '0 : (a_q >> b_q[SHW-1:0]);
`ifdef SEQ_ALU_MUL_EN
      OPW'(OP_MUL): begin
        res   = mul_lo;
        res_c = |mul_hi;
      end
`endif
      default: res_err = 1'b1;
    endcase
    if (res_err) begin
      res    = '0;
      res_st = STATUS_ILLEGAL;
    end else begin
      res_st[ST_N] = res[WIDTH-1];
      res_st[ST_Z] = (res == '0);
      res_st[ST_C] = res_c;
      res_st[ST_V] = res_v;
    end
  end

  // State, handshake flags, captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      status    <= '0;
      err       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state == S_IDLE) && (state_next == S_IDLE);
      out_valid <= (state == S_DONE) && (state_next == S_DONE);
      if (accept) begin
        op_q <= opcode;
        a_q  <= in0;
        b_q  <= in1;
      end
      if (load_out) begin
        out    <= res;
        status <= res_st;
        err    <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus hand sequences for hold, back-to-back and reset.
module tb_seq_alu;

  localparam int unsigned W   = 16;
  localparam int unsigned OPW = 4;
  localparam int unsigned NV  = 17;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] opcode;
  logic [W-1:0]   in0;
  logic [W-1:0]   in1;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out;
  logic [3:0]     status;
  logic           err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic [3:0]  st;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .status    (status),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Present a request, let it be accepted, then scramble inputs (must be ignored)
  task automatic issue(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy);
    wait_ready(name);
    opcode    = op;
    in0       = a;
    in1       = b;
    in_valid  = 1'b1;
    tick();
    out_ready = rdy;
    opcode    = OPW'($urandom);
    in0       = W'($urandom);
    in1       = W'($urandom);
    chk({name, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    issue(name, v.op, v.a, v.b, 1'b1);
    wait_valid(lat);
    chk({name, "_lat"}, 32'(lat), 32'(v.lat));
    chk({name, "_out"}, 32'(out), 32'(v.y));
    chk({name, "_st"}, 32'(status), 32'(v.st));
    chk({name, "_err"}, 32'(err), 32'(v.e));
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk({name, "_vdrop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0]  = '{4'd3, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 2};
    vecs[1]  = '{4'd4, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b0, 2};
    vecs[2]  = '{4'd4, 16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b0, 2};
    vecs[3]  = '{4'd5, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 1'b0, 2};
    vecs[4]  = '{4'd6, 16'h8000, 16'h0010, 16'h0000, 4'b0100, 1'b0, 2};
    vecs[5]  = '{4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b1, 2};
    vecs[6]  = '{4'd0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1'b0, 2};
    vecs[7]  = '{4'd1, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0, 2};
    vecs[8]  = '{4'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1'b0, 2};
    vecs[9]  = '{4'd3, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0, 2};
    vecs[10] = '{4'd3, 16'h8000, 16'h8000, 16'h0000, 4'b0111, 1'b0, 2};
    vecs[11] = '{4'd4, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 2};
    vecs[12] = '{4'd6, 16'h8000, 16'h0004, 16'h0800, 4'b0000, 1'b0, 2};
    vecs[13] = '{4'd5, 16'h0001, 16'h0100, 16'h0000, 4'b0100, 1'b0, 2};
`ifdef SEQ_ALU_MUL_EN
    vecs[14] = '{4'd7, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 1'b0, 18};
    vecs[15] = '{4'd7, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 18};
    vecs[16] = '{4'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0, 18};
`else
    vecs[14] = '{4'd7, 16'h0100, 16'h0100, 16'h0000, 4'b0100, 1'b1, 2};
    vecs[15] = '{4'd7, 16'h0003, 16'h0005, 16'h0000, 4'b0100, 1'b1, 2};
    vecs[16] = '{4'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b1, 2};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    in0       = '0;
    in1       = '0;

    // Reset state, then in_ready rises on the first edge after release
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #2 rst = 1'b0;
    chk("rel_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("rel_ready_high", 32'(in_ready), 32'd1);

    for (int i = 0; i < int'(NV); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Hold result in DONE while inputs toggle; release then see in_ready one cycle later
    issue("hold", 4'd3, 16'h0001, 16'h0002, 1'b0);
    wait_valid(lat);
    chk("hold_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      opcode   = OPW'($urandom);
      in0      = W'($urandom);
      in1      = W'($urandom);
      tick();
      chk($sformatf("hold%0d_out", k), 32'(out), 32'h0003);
      chk($sformatf("hold%0d_st", k), 32'(status), 32'h0);
      chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_rel_valid", 32'(out_valid), 32'd0);
    chk("hold_rel_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("hold_rel_ready1", 32'(in_ready), 32'd1);

    // Back-to-back request right after in_ready returns
    run_vec("b2b", '{4'd2, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 1'b0, 2});

    // Asynchronous reset while a result is pending in DONE
    issue("rdone", 4'd3, 16'h7FFF, 16'h0001, 1'b0);
    wait_valid(lat);
    chk("rdone_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rdone_valid", 32'(out_valid), 32'd0);
    chk("rdone_out", 32'(out), 32'd0);
    chk("rdone_status", 32'(status), 32'd0);
    chk("rdone_err", 32'(err), 32'd0);
    chk("rdone_ready", 32'(in_ready), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    chk("rdone_ready_back", 32'(in_ready), 32'd1);
    run_vec("post_rst", '{4'd3, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0, 2});

`ifdef SEQ_ALU_MUL_EN
    // Abort an in-flight multiply, then confirm a fresh multiply is clean
    issue("rmul", 4'd7, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("rmul_valid", 32'(out_valid), 32'd0);
    chk("rmul_ready", 32'(in_ready), 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    run_vec("post_rmul", '{4'd7, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 18});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
